// File: rtl/hbridge_driver.sv
// hbridge_driver: two-channel H-bridge controller with a shared PWM counter.
// Each channel has its own FSM: IDLE, DEAD, RAMP, RUN and BRAKE. Every
// direction reversal, and every exit from brake, passes through a dead
// interval in which both bridge sides are off. The outputs are registered,
// so a command sampled on one edge is visible on the pins after that edge.
//
// Parameters
//   PWM_BITS    width of the PWM counter and of the duty value
//   DEAD_CYCLES number of clocks both bridge sides are held off
//   RAMP_STEP   duty increment per PWM period during soft start
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   rst       synchronous reset, active high
//   motor_in  direction command; [1:0] ch0, [3:2] ch1; 01 fwd, 10 rev, 00/11 brake
//   motor_en  run enable, one bit per channel
//   duty      target duty shared by both channels
//   hb_in     registered bridge direction pins (same mapping as motor_in)
//   hb_en     registered PWM enable pins, one per channel
//   busy      bit n high while channel n is in DEAD or RAMP
//
// Build option
//   HBRIDGE_SOFT_START_EN  defined: RAMP adds RAMP_STEP at each PWM period
//                          boundary until it reaches duty.
//                          undefined: RAMP lasts one clock and loads duty.
module hbridge_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned RAMP_STEP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          motor_in,
  input  logic [1:0]          motor_en,
  input  logic [PWM_BITS-1:0] duty,
  output logic [3:0]          hb_in,
  output logic [1:0]          hb_en,
  output logic [1:0]          busy
);

  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD,
    S_RAMP,
    S_RUN,
    S_BRAKE
  } state_e;

  // A zero step would stall soft start forever.
  if (RAMP_STEP == 0) begin : g_bad_ramp_step
    $error("hbridge_driver: RAMP_STEP must be at least 1");
  end

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

`ifdef HBRIDGE_SOFT_START_EN
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(RAMP_STEP);
  logic period_end;
  // The counter is at all-ones: the next edge wraps it and starts a period.
  assign period_end = &pwm_cnt_q;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [1:0]          cmd;
    logic                drive;
    logic                run_en;
    state_e              state_q, state_d;
    logic [1:0]          dir_q, dir_d;
    logic [PWM_BITS-1:0] cur_q, cur_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [1:0]          pair_q, pair_d;
    logic                pwm_en_q, pwm_en_d;
    logic                busy_q, busy_d;
`ifdef HBRIDGE_SOFT_START_EN
    logic [PWM_BITS:0]   ramp_sum;
`endif

    assign cmd    = motor_in[2*g +: 2];
    assign drive  = cmd[0] ^ cmd[1];
    assign run_en = motor_en[g];

    always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cur_d   = cur_q;
      dead_d  = dead_q;
`ifdef HBRIDGE_SOFT_START_EN
      ramp_sum = {1'b0, cur_q} + STEP_W;
`endif
      case (state_q)
        S_IDLE: begin
          if (run_en) begin
            cur_d = '0;
            if (drive) begin
              state_d = S_RAMP;
              dir_d   = cmd;
            end else begin
              state_d = S_BRAKE;
            end
          end
        end
        S_RAMP, S_RUN: begin
          if (!run_en) begin
            state_d = S_IDLE;
            cur_d   = '0;
          end else if (!drive) begin
            state_d = S_BRAKE;
            cur_d   = '0;
          end else if (cmd != dir_q) begin
            state_d = S_DEAD;
            dead_d  = DEAD_LOAD;
            cur_d   = '0;
          end else if (state_q == S_RUN) begin
            cur_d = duty;
          end else begin
`ifdef HBRIDGE_SOFT_START_EN
            if (cur_q == duty) begin
              state_d = S_RUN;
            end else if (period_end) begin
              // Saturate at the target; this also pulls cur_duty down if the
              // target dropped below it mid-ramp.
              if (ramp_sum >= {1'b0, duty}) begin
                cur_d = duty;
              end else begin
                cur_d = ramp_sum[PWM_BITS-1:0];
              end
            end
`else
            cur_d   = duty;
            state_d = S_RUN;
`endif
          end
        end
        S_DEAD: begin
          // Direction toggles are ignored here; only disable cuts it short.
          if (!run_en) begin
            state_d = S_IDLE;
            dead_d  = '0;
          end else if (dead_q <= DW'(1)) begin
            dead_d = '0;
            cur_d  = '0;
            if (drive) begin
              state_d = S_RAMP;
              dir_d   = cmd;
            end else begin
              state_d = S_BRAKE;
            end
          end else begin
            dead_d = dead_q - 1'b1;
          end
        end
        S_BRAKE: begin
          cur_d = '0;
          if (!run_en) begin
            state_d = S_IDLE;
          end else if (drive) begin
            state_d = S_DEAD;
            dead_d  = DEAD_LOAD;
          end
        end
        default: begin
          state_d = S_IDLE;
          cur_d   = '0;
          dead_d  = '0;
        end
      endcase
    end

    // Pins are derived from next-state values so the registered outputs
    // line up with the state they describe, and hb_en matches pwm_cnt_q.
    always_comb begin
      pair_d   = 2'b00;
      pwm_en_d = 1'b0;
      busy_d   = (state_d == S_DEAD) || (state_d == S_RAMP);
      case (state_d)
        S_RAMP, S_RUN: begin
          pair_d   = dir_d;
          pwm_en_d = (pwm_cnt_d < cur_d);
        end
        S_BRAKE: begin
          pair_d   = 2'b11;
          pwm_en_d = 1'b1;
        end
        default: begin
          pair_d   = 2'b00;
          pwm_en_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= S_IDLE;
        dir_q    <= '0;
        cur_q    <= '0;
        dead_q   <= '0;
        pair_q   <= '0;
        pwm_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        dir_q    <= dir_d;
        cur_q    <= cur_d;
        dead_q   <= dead_d;
        pair_q   <= pair_d;
        pwm_en_q <= pwm_en_d;
        busy_q   <= busy_d;
      end
    end
  end

  assign hb_in = {g_ch[1].pair_q, g_ch[0].pair_q};
  assign hb_en = {g_ch[1].pwm_en_q, g_ch[0].pwm_en_q};
  assign busy  = {g_ch[1].busy_q, g_ch[0].busy_q};

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed bench for hbridge_driver (PWM_BITS=8, DEAD_CYCLES=16, RAMP_STEP=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_hbridge_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] motor_in;
  logic [1:0] motor_en;
  logic [7:0] duty;
  logic [3:0] hb_in;
  logic [1:0] hb_en;
  logic [1:0] busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rev_bad = 0;
  logic [7:0] pcnt;
  logic [1:0] prev_pair [2];

  always #5 clk = ~clk;

  hbridge_driver #(.PWM_BITS(8), .DEAD_CYCLES(16), .RAMP_STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .motor_in (motor_in),
    .motor_en (motor_en),
    .duty     (duty),
    .hb_in    (hb_in),
    .hb_en    (hb_en),
    .busy     (busy)
  );

  // Watch for a pin pair flipping straight between 01 and 10.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst !== 1'b1 &&
          ((hb_in[2*c +: 2] == 2'b01 && prev_pair[c] == 2'b10) ||
           (hb_in[2*c +: 2] == 2'b10 && prev_pair[c] == 2'b01)))
        rev_bad++;
      prev_pair[c] = hb_in[2*c +: 2];
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) pcnt = 8'd0;
    else     pcnt = pcnt + 8'd1;
    #1;
  endtask

  // 256 consecutive samples of one channel: number of high hb_en clocks, and
  // samples where hb_en disagrees with pcnt<duty or the pair is not exp_pair.
  task automatic measure(input int ch, input logic [1:0] exp_pair, input int exp_duty,
                         output int highs, output int bad);
    highs = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (hb_en[ch] === 1'b1) highs++;
      if (hb_en[ch] !== (int'(pcnt) < exp_duty) || hb_in[2*ch +: 2] !== exp_pair) bad++;
    end
  endtask

  // Leave RAMP for RUN.
  task automatic settle(input int ch);
`ifdef HBRIDGE_SOFT_START_EN
    int waited = 0;
    while (busy[ch] === 1'b1 && waited < 64*256) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (busy[ch] !== 1'b0) begin
      n_bad++;
      $display("FAIL ramp_timeout ch%0d: busy=%b after %0d clocks, required 0", ch, busy[ch], waited);
    end
`else
    tick();
    n_cmp++;
    if (busy[ch] !== 1'b0) begin
      n_bad++;
      $display("FAIL ramp_one_clock ch%0d: busy=%b, required 0", ch, busy[ch]);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; motor_en = 2'b00; motor_in = 4'b0000; duty = 8'd0;
    tick(); tick();
    n_cmp++; if (hb_in !== 4'b0000) begin n_bad++; $display("FAIL reset_hb_in: got %b, required 0000", hb_in); end
    n_cmp++; if (hb_en !== 2'b00)   begin n_bad++; $display("FAIL reset_hb_en: got %b, required 00", hb_en); end
    n_cmp++; if (busy !== 2'b00)    begin n_bad++; $display("FAIL reset_busy: got %b, required 00", busy); end
    rst = 1'b0;
  endtask

  task automatic test_start_run();
    int highs, bad;
    duty = 8'd200; motor_en = 2'b01; motor_in = 4'b0001;
    tick();
    n_cmp++; if (hb_in !== 4'b0001) begin n_bad++; $display("FAIL start_dir: got %b, required 0001", hb_in); end
    n_cmp++; if (busy !== 2'b01)    begin n_bad++; $display("FAIL start_busy: got %b, required 01", busy); end
    n_cmp++; if (hb_en !== 2'b00)   begin n_bad++; $display("FAIL start_en_zero: got %b, required 00", hb_en); end
    settle(0);
    measure(0, 2'b01, 200, highs, bad);
    n_cmp++; if (highs !== 200) begin n_bad++; $display("FAIL run_highs_200: got %0d, required 200", highs); end
    n_cmp++; if (bad !== 0)     begin n_bad++; $display("FAIL run_phase_200: got %0d bad samples, required 0", bad); end
    duty = 8'd0;
    tick();
    measure(0, 2'b01, 0, highs, bad);
    n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL duty0_highs: got %0d, required 0", highs); end
    n_cmp++; if (bad !== 0)   begin n_bad++; $display("FAIL duty0_dir_held: got %0d bad samples, required 0", bad); end
    duty = 8'd128;
    tick();
    measure(0, 2'b01, 128, highs, bad);
    n_cmp++; if (highs !== 128) begin n_bad++; $display("FAIL run_highs_128: got %0d, required 128", highs); end
  endtask

  task automatic test_reversal();
    int dead_bad = 0;
    motor_in = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!(hb_in[1:0] === 2'b00 && hb_en[0] === 1'b0 && busy[0] === 1'b1)) dead_bad++;
      if (i == 4) motor_in = 4'b0001;
      if (i == 9) motor_in = 4'b0010;
    end
    n_cmp++; if (dead_bad !== 0) begin n_bad++; $display("FAIL rev_dead_16: got %0d bad dead clocks, required 0", dead_bad); end
    tick();
    n_cmp++; if (hb_in[1:0] !== 2'b10) begin n_bad++; $display("FAIL rev_dir_after_dead: got %b, required 10", hb_in[1:0]); end
    n_cmp++; if (busy[0] !== 1'b1)     begin n_bad++; $display("FAIL rev_ramp_busy: got %b, required 1", busy[0]); end
    n_cmp++; if (hb_en[0] !== 1'b0)    begin n_bad++; $display("FAIL rev_ramp_from_0: got %b, required 0", hb_en[0]); end
    settle(0);
  endtask

  task automatic test_brake();
    int dead_bad = 0;
    motor_in = 4'b0011;
    tick();
    n_cmp++; if (hb_in[1:0] !== 2'b11) begin n_bad++; $display("FAIL brake_pair: got %b, required 11", hb_in[1:0]); end
    n_cmp++; if (hb_en[0] !== 1'b1)    begin n_bad++; $display("FAIL brake_en: got %b, required 1", hb_en[0]); end
    n_cmp++; if (busy[0] !== 1'b0)     begin n_bad++; $display("FAIL brake_busy: got %b, required 0", busy[0]); end
    tick(); tick(); tick();
    motor_in = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!(hb_in[1:0] === 2'b00 && hb_en[0] === 1'b0 && busy[0] === 1'b1)) dead_bad++;
    end
    n_cmp++; if (dead_bad !== 0) begin n_bad++; $display("FAIL brake_dead_16: got %0d bad dead clocks, required 0", dead_bad); end
    tick();
    n_cmp++; if (hb_in[1:0] !== 2'b01) begin n_bad++; $display("FAIL brake_exit_dir: got %b, required 01", hb_in[1:0]); end
    settle(0);
  endtask

  task automatic test_channel_disable();
    int highs, bad;
    motor_en = 2'b11; motor_in = 4'b1001; duty = 8'd128;
    tick();
    n_cmp++; if (busy !== 2'b10) begin n_bad++; $display("FAIL ch1_start_busy: got %b, required 10", busy); end
    settle(1);
    n_cmp++; if (hb_in !== 4'b1001) begin n_bad++; $display("FAIL both_run_dir: got %b, required 1001", hb_in); end
    motor_en = 2'b10;
    tick();
    n_cmp++; if (hb_in !== 4'b1000) begin n_bad++; $display("FAIL ch0_idle_dir: got %b, required 1000", hb_in); end
    n_cmp++; if (hb_en[0] !== 1'b0) begin n_bad++; $display("FAIL ch0_idle_en: got %b, required 0", hb_en[0]); end
    n_cmp++; if (busy !== 2'b00)    begin n_bad++; $display("FAIL disable_busy: got %b, required 00", busy); end
    measure(1, 2'b10, 128, highs, bad);
    n_cmp++; if (highs !== 128) begin n_bad++; $display("FAIL ch1_highs_128: got %0d, required 128", highs); end
    n_cmp++; if (bad !== 0)     begin n_bad++; $display("FAIL ch1_phase: got %0d bad samples, required 0", bad); end
    n_cmp++; if (hb_in[1:0] !== 2'b00 || hb_en[0] !== 1'b0) begin
      n_bad++; $display("FAIL ch0_stays_idle: got pair %b en %b, required 00/0", hb_in[1:0], hb_en[0]);
    end
  endtask

  task automatic test_idle_brake();
    motor_en = 2'b01; motor_in = 4'b0000;
    tick();
    n_cmp++; if (hb_in !== 4'b0011) begin n_bad++; $display("FAIL idle_to_brake: got %b, required 0011", hb_in); end
    n_cmp++; if (hb_en !== 2'b01)   begin n_bad++; $display("FAIL idle_brake_en: got %b, required 01", hb_en); end
    motor_en = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_dead();
    int highs, bad;
    motor_en = 2'b01; motor_in = 4'b0001; duty = 8'd100;
    tick();
    settle(0);
    motor_in = 4'b0010;
    tick();
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_dead: got busy %b, required 1", busy[0]); end
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({hb_in, hb_en, busy} !== 8'h00) begin
      n_bad++; $display("FAIL rst_mid_dead: got hb_in %b hb_en %b busy %b, required all 0", hb_in, hb_en, busy);
    end
    rst = 1'b0;
    tick();
    n_cmp++; if (hb_in !== 4'b0010) begin n_bad++; $display("FAIL post_rst_dir: got %b, required 0010", hb_in); end
    n_cmp++; if (busy !== 2'b01)    begin n_bad++; $display("FAIL post_rst_ramp: got %b, required 01", busy); end
    n_cmp++; if (hb_en !== 2'b00)   begin n_bad++; $display("FAIL post_rst_duty0: got %b, required 00", hb_en); end
    settle(0);
    measure(0, 2'b10, 100, highs, bad);
    n_cmp++; if (highs !== 100) begin n_bad++; $display("FAIL post_rst_highs_100: got %0d, required 100", highs); end
  endtask

  task automatic test_dead_disable();
    motor_in = 4'b0001;
    tick(); tick(); tick();
    motor_en = 2'b00;
    tick();
    n_cmp++; if ({hb_in, busy} !== 6'b000000) begin
      n_bad++; $display("FAIL dead_disable_idle: got hb_in %b busy %b, required 0000/00", hb_in, busy);
    end
    motor_en = 2'b01;
    tick();
    n_cmp++; if (hb_in !== 4'b0001 || busy !== 2'b01) begin
      n_bad++; $display("FAIL idle_restart_ramp: got hb_in %b busy %b, required 0001/01", hb_in, busy);
    end
  endtask

  initial begin
    prev_pair[0] = 2'b00;
    prev_pair[1] = 2'b00;
    test_reset();
    test_start_run();
    test_reversal();
    test_brake();
    test_channel_disable();
    test_idle_brake();
    test_reset_mid_dead();
    test_dead_disable();
    n_cmp++; if (rev_bad !== 0) begin n_bad++; $display("FAIL no_direct_reversal: got %0d reversals, required 0", rev_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
